mem_access_unit: RTL and testbench

MEM-stage data-memory access unit, directly upstream of the load-merge logic in the writeback path.
- Takes a load/store from the EX/MEM register and generates big-endian byte enables and lane-aligned write data for SW/SH/SB/SWL/SWR.
- Runs a req/ack handshake with a variable-latency data memory and stalls the pipeline while waiting.
- Registers the read word, LoadType and LoadByte (address bits [1:0]) into the MEM/WB outputs that feed load merging.

---
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with big-endian lane steering,
// req/ack memory handshake with timeout, and registered MEM/WB outputs.
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_store_type,
    input  logic [1:0]  in_load_type,
    input  logic        in_reg_wr,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_din,
    output logic [1:0]  wb_load_type,
    output logic [1:0]  wb_load_byte,
    output logic        wb_reg_wr,
    output logic        addr_err,
    output logic        bus_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;
    logic [TO_W-1:0] cnt;
    logic ld, rw;
    logic [1:0] k;
    logic is_ld, is_st, st_ok, mis;
    logic [3:0] be;
    logic [31:0] wd;
    always_comb begin
        k = in_addr[1:0];
        is_ld = in_mem_read;
        is_st = in_mem_write & ~in_mem_read;
        st_ok = in_store_type <= 3'd4;
        mis = is_ld ? (in_load_type == 2'b10 && k != 2'd0)
                    : is_st & ((in_store_type == 3'd0 && k != 2'd0) || (in_store_type == 3'd1 && k[0]));
        // Byte offset 0 is the most significant lane (big-endian)
        be = in_store_type == 3'd0 ? 4'hf :
             in_store_type == 3'd1 ? (k[1] ? 4'h3 : 4'hc) :
             in_store_type == 3'd2 ? 4'h8 >> k :
             in_store_type == 3'd3 ? 4'hf >> k :
                                     4'hf << (2'd3 - k);
        wd = in_store_type == 3'd0 ? in_wdata :
             in_store_type == 3'd1 ? {2{in_wdata[15:0]}} :
             in_store_type == 3'd2 ? {4{in_wdata[7:0]}} :
             in_store_type == 3'd3 ? in_wdata >> {k, 3'b000} :
                                     in_wdata << {~k, 3'b000};
    end
    assign stall = state == WAIT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            ld <= 1'b0;
            rw <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
            wb_valid <= 1'b0;
            wb_din <= '0;
            wb_load_type <= '0;
            wb_load_byte <= '0;
            wb_reg_wr <= 1'b0;
            addr_err <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            addr_err <= 1'b0;
            bus_err <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    if (mis) begin
                        addr_err <= 1'b1;
                    end else if (is_ld | (is_st & st_ok)) begin
                        state <= WAIT;
                        cnt <= '0;
                        mem_req <= 1'b1;
                        mem_we <= is_st;
                        mem_addr <= {in_addr[31:2], 2'b00};
                        mem_be <= is_ld ? 4'hf : be;
                        mem_wdata <= is_ld ? 32'd0 : wd;
                        ld <= is_ld;
                        rw <= in_reg_wr;
                        wb_load_type <= in_load_type;
                        wb_load_byte <= k;
                    end else begin
                        wb_valid <= 1'b1;
                        wb_din <= in_addr;
                        wb_load_type <= in_load_type;
                        wb_load_byte <= k;
                        wb_reg_wr <= in_reg_wr & ~is_st;
                    end
                end
            end else if (mem_ack) begin
                state <= IDLE;
                mem_req <= 1'b0;
                wb_valid <= 1'b1;
                wb_din <= ld ? mem_rdata : 32'd0;
                wb_reg_wr <= ld & rw;
            end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                state <= IDLE;
                mem_req <= 1'b0;
                bus_err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of lane steering, handshake, timeout,
// misalignment and reset behaviour of mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst, in_valid, in_mem_read, in_mem_write, in_reg_wr;
    logic [2:0] in_store_type;
    logic [1:0] in_load_type;
    logic [31:0] in_addr, in_wdata, mem_rdata;
    logic mem_ack;
    logic stall, mem_req, mem_we, wb_valid, wb_reg_wr, addr_err, bus_err;
    logic [31:0] mem_addr, mem_wdata, wb_din;
    logic [3:0] mem_be;
    logic [1:0] wb_load_type, wb_load_byte;
    int checks = 0, failures = 0;
    int reqc, stc;

    mem_access_unit #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_store_type(in_store_type),
        .in_load_type(in_load_type), .in_reg_wr(in_reg_wr), .in_addr(in_addr),
        .in_wdata(in_wdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_din(wb_din), .wb_load_type(wb_load_type), .wb_load_byte(wb_load_byte),
        .wb_reg_wr(wb_reg_wr), .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction, then run the handshake; ack_at=0 means never ack.
    task automatic op(input logic rd, input logic wr, input logic [2:0] st, input logic [1:0] lt,
                      input logic rw, input logic [31:0] a, input logic [31:0] d, input int ack_at);
        in_mem_read = rd; in_mem_write = wr; in_store_type = st; in_load_type = lt;
        in_reg_wr = rw; in_addr = a; in_wdata = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reqc = 0; stc = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!mem_req && !stall) break;
            reqc += int'(mem_req);
            stc += int'(stall);
            mem_ack = (i == ack_at);
            tick();
            mem_ack = 1'b0;
        end
    endtask

    typedef struct { logic [2:0] st; logic [1:0] k; logic [3:0] be; logic [31:0] wd; } vec_t;
    vec_t vt[12] = '{
        '{3'd0, 2'd0, 4'hf, 32'h1122_3344}, '{3'd1, 2'd0, 4'hc, 32'h3344_3344},
        '{3'd1, 2'd2, 4'h3, 32'h3344_3344}, '{3'd2, 2'd0, 4'h8, 32'h4444_4444},
        '{3'd2, 2'd2, 4'h2, 32'h4444_4444}, '{3'd2, 2'd3, 4'h1, 32'h4444_4444},
        '{3'd3, 2'd0, 4'hf, 32'h1122_3344}, '{3'd3, 2'd1, 4'h7, 32'h0011_2233},
        '{3'd3, 2'd3, 4'h1, 32'h0000_0011}, '{3'd4, 2'd0, 4'h8, 32'h4400_0000},
        '{3'd4, 2'd1, 4'hc, 32'h3344_0000}, '{3'd4, 2'd3, 4'hf, 32'h1122_3344}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_store_type = 3'd0; in_load_type = 2'd0; in_reg_wr = 1'b0;
        in_addr = '0; in_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_be", mem_be, 0);

        op(0, 0, 3'd0, 2'b00, 1, 32'h1234_5678, 0, 0);
        check("nm_req", reqc, 0);
        check("nm_wbv", wb_valid, 1);
        check("nm_din", wb_din, 32'h1234_5678);
        check("nm_rw", wb_reg_wr, 1);
        check("nm_stall", stall, 0);

        mem_rdata = 32'hAABB_CCDD;
        op(1, 0, 3'd0, 2'b10, 1, 32'h100, 0, 3);
        check("lw_reqc", reqc, 3);
        check("lw_stallc", stc, 3);
        check("lw_be", mem_be, 4'hf);
        check("lw_we", mem_we, 0);
        check("lw_addr", mem_addr, 32'h100);
        check("lw_wbv", wb_valid, 1);
        check("lw_din", wb_din, 32'hAABB_CCDD);
        check("lw_lt", wb_load_type, 2'b10);
        check("lw_lb", wb_load_byte, 2'b00);
        check("lw_rw", wb_reg_wr, 1);
        tick();
        check("lw_pulse", wb_valid, 0);

        for (int i = 0; i < 12; i++) begin
            op(0, 1, vt[i].st, 2'b00, 1, 32'h200 + 32'(vt[i].k), 32'h1122_3344, 1);
            check($sformatf("st%0d_k%0d_be", vt[i].st, vt[i].k), mem_be, vt[i].be);
            check($sformatf("st%0d_k%0d_wd", vt[i].st, vt[i].k), mem_wdata, vt[i].wd);
            check($sformatf("st%0d_k%0d_we", vt[i].st, vt[i].k), mem_we, 1);
            check($sformatf("st%0d_k%0d_addr", vt[i].st, vt[i].k), mem_addr, 32'h200);
            check($sformatf("st%0d_k%0d_reqc", vt[i].st, vt[i].k), reqc, 1);
            check($sformatf("st%0d_k%0d_wbv", vt[i].st, vt[i].k), wb_valid, 1);
            check($sformatf("st%0d_k%0d_rw", vt[i].st, vt[i].k), wb_reg_wr, 0);
            check($sformatf("st%0d_k%0d_din", vt[i].st, vt[i].k), wb_din, 0);
        end

        op(1, 0, 3'd0, 2'b10, 1, 32'h102, 0, 1);
        check("mis_reqc", reqc, 0);
        check("mis_err", addr_err, 1);
        check("mis_wbv", wb_valid, 0);
        tick();
        check("mis_pulse", addr_err, 0);
        op(0, 1, 3'd1, 2'b00, 0, 32'h101, 32'h1, 1);
        check("sh_mis_err", addr_err, 1);
        check("sh_mis_reqc", reqc, 0);

        mem_rdata = 32'h0102_0304;
        op(1, 0, 3'd0, 2'b01, 1, 32'h103, 0, 1);
        check("lwl_reqc", reqc, 1);
        check("lwl_err", addr_err, 0);
        check("lwl_addr", mem_addr, 32'h100);
        check("lwl_lb", wb_load_byte, 2'b11);
        check("lwl_lt", wb_load_type, 2'b01);
        check("lwl_din", wb_din, 32'h0102_0304);

        op(0, 1, 3'd7, 2'b00, 1, 32'h55, 32'h9, 1);
        check("ill_reqc", reqc, 0);
        check("ill_wbv", wb_valid, 1);
        check("ill_din", wb_din, 32'h55);
        check("ill_rw", wb_reg_wr, 0);

        op(1, 0, 3'd0, 2'b10, 1, 32'h300, 0, 0);
        check("to_reqc", reqc, 4);
        check("to_berr", bus_err, 1);
        check("to_wbv", wb_valid, 0);
        check("to_stall", stall, 0);
        tick();
        check("to_pulse", bus_err, 0);
        op(0, 0, 3'd0, 2'b00, 1, 32'hDEAD_0001, 0, 0);
        check("to_next_wbv", wb_valid, 1);
        check("to_next_din", wb_din, 32'hDEAD_0001);

        mem_rdata = 32'hCAFE_F00D;
        op(1, 0, 3'd0, 2'b10, 1, 32'h304, 0, 4);
        check("ackw_reqc", reqc, 4);
        check("ackw_berr", bus_err, 0);
        check("ackw_wbv", wb_valid, 1);
        check("ackw_din", wb_din, 32'hCAFE_F00D);

        in_mem_read = 1'b1; in_mem_write = 1'b0; in_load_type = 2'b10;
        in_addr = 32'h400; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rw_req", mem_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_req0", mem_req, 0);
        check("rw_stall0", stall, 0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check("rw_wbv", wb_valid, 0);
        check("rw_din", wb_din, 0);
        check("rw_addr", mem_addr, 0);
        check("rw_be", mem_be, 0);
        check("rw_req1", mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
